// File: rtl/counter_step_checker_if.sv
// Signal bundle between the up/down counter tap and the step checker.
// The master drives the sampled counter side; the slave (checker) returns status.
interface counter_step_checker_if #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned WRAP_W = 8
);
   logic              en;
   logic              sel;
   logic [WIDTH-1:0]  cnt_in;
   logic              clr;
   logic [WRAP_W-1:0] ovf_cnt;
   logic [WRAP_W-1:0] unf_cnt;
   logic              wrap_ev;
   logic              err;
   logic [WIDTH-1:0]  err_exp;
   logic [WIDTH-1:0]  err_got;
   logic              busy;

   modport master (
      output en, sel, cnt_in, clr,
      input  ovf_cnt, unf_cnt, wrap_ev, err, err_exp, err_got, busy
   );

   modport slave (
      input  en, sel, cnt_in, clr,
      output ovf_cnt, unf_cnt, wrap_ev, err, err_exp, err_got, busy
   );
endinterface

// File: rtl/counter_step_checker.sv
// Monitors an up/down counter: every sampled step must be +1/-1 per the previous
// direction select; counts legal wraps (saturating) and latches the first fault.
module counter_step_checker #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned WRAP_W = 8
) (
   input logic                    clk,
   input logic                    rst,
   counter_step_checker_if.slave  bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  prev_cnt, prev_cnt_n;
   logic              prev_sel, prev_sel_n;
   logic [WRAP_W-1:0] ovf_q, ovf_n;
   logic [WRAP_W-1:0] unf_q, unf_n;
   logic              wrap_q, wrap_n;
   logic              err_q, err_n;
   logic [WIDTH-1:0]  exp_q, exp_n;
   logic [WIDTH-1:0]  got_q, got_n;
   logic [WIDTH-1:0]  expected;

   assign expected = prev_sel ? prev_cnt + 1'b1 : prev_cnt - 1'b1;

   always_ff @(posedge clk) begin
      if (rst || bus.clr) begin
         state    <= IDLE;
         prev_cnt <= '0;
         prev_sel <= 1'b0;
         ovf_q    <= '0;
         unf_q    <= '0;
         wrap_q   <= 1'b0;
         err_q    <= 1'b0;
         exp_q    <= '0;
         got_q    <= '0;
      end else begin
         state    <= state_n;
         prev_cnt <= prev_cnt_n;
         prev_sel <= prev_sel_n;
         ovf_q    <= ovf_n;
         unf_q    <= unf_n;
         wrap_q   <= wrap_n;
         err_q    <= err_n;
         exp_q    <= exp_n;
         got_q    <= got_n;
      end
   end

   always_comb begin
      state_n    = state;
      prev_cnt_n = prev_cnt;
      prev_sel_n = prev_sel;
      ovf_n      = ovf_q;
      unf_n      = unf_q;
      wrap_n     = 1'b0;
      err_n      = err_q;
      exp_n      = exp_q;
      got_n      = got_q;
      case (state)
         IDLE: begin
            if (bus.en) begin
               prev_cnt_n = bus.cnt_in;
               prev_sel_n = bus.sel;
               state_n    = TRACK;
            end
         end
         TRACK: begin
            if (!bus.en) begin
               state_n = IDLE;
            end else if (bus.cnt_in == expected) begin
               prev_cnt_n = bus.cnt_in;
               prev_sel_n = bus.sel;
               // Wrap is judged on the step just taken, i.e. from the previous reference.
               if (prev_sel && (prev_cnt == '1)) begin
                  wrap_n = 1'b1;
                  if (ovf_q != '1) ovf_n = ovf_q + 1'b1;
               end
               if (!prev_sel && (prev_cnt == '0)) begin
                  wrap_n = 1'b1;
                  if (unf_q != '1) unf_n = unf_q + 1'b1;
               end
            end else begin
               state_n = FAULT;
               err_n   = 1'b1;
               exp_n   = expected;
               got_n   = bus.cnt_in;
            end
         end
         FAULT: begin
            state_n = FAULT;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.ovf_cnt = ovf_q;
   assign bus.unf_cnt = unf_q;
   assign bus.wrap_ev = wrap_q;
   assign bus.err     = err_q;
   assign bus.err_exp = exp_q;
   assign bus.err_got = got_q;
   assign bus.busy    = (state == TRACK);
endmodule

// File: tb/tb_counter_step_checker.sv
// Directed bench for counter_step_checker: a behavioural model pushes expected
// status per driven cycle into a queue, popped and compared after each edge.
module tb_counter_step_checker;
   localparam int unsigned WIDTH  = 4;
   localparam int unsigned WRAP_W = 8;

   typedef struct {
      logic [7:0] ovf;
      logic [7:0] unf;
      logic       wrap;
      logic       err;
      logic [3:0] eexp;
      logic [3:0] egot;
      logic       busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   wrap_seen = 0;
   exp_t sb[$];

   // model state: 0 idle, 1 track, 2 fault
   int         m_state = 0;
   logic [3:0] m_prev = '0;
   logic       m_psel = 1'b0;
   logic [7:0] m_ovf = '0, m_unf = '0;
   logic       m_err = 1'b0;
   logic [3:0] m_exp = '0, m_got = '0;
   int         m_ovf_total = 0, m_unf_total = 0;

   counter_step_checker_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

   counter_step_checker #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic s, input logic [3:0] c,
                       input logic cl);
      exp_t       x;
      logic       w;
      logic [3:0] nxt;
      rst = r; bus.en = e; bus.sel = s; bus.cnt_in = c; bus.clr = cl;
      w = 1'b0;
      if (r || cl) begin
         m_state = 0; m_prev = '0; m_psel = 1'b0; m_ovf = '0; m_unf = '0;
         m_err = 1'b0; m_exp = '0; m_got = '0;
      end else if (m_state == 0) begin
         if (e) begin m_prev = c; m_psel = s; m_state = 1; end
      end else if (m_state == 1) begin
         if (!e) m_state = 0;
         else begin
            nxt = m_psel ? 4'(m_prev + 4'd1) : 4'(m_prev - 4'd1);
            if (c == nxt) begin
               if (m_psel && m_prev == 4'd15) begin
                  w = 1'b1; m_ovf_total++;
                  if (m_ovf != 8'd255) m_ovf = m_ovf + 8'd1;
               end
               if (!m_psel && m_prev == 4'd0) begin
                  w = 1'b1; m_unf_total++;
                  if (m_unf != 8'd255) m_unf = m_unf + 8'd1;
               end
               m_prev = c; m_psel = s;
            end else begin
               m_state = 2; m_err = 1'b1; m_exp = nxt; m_got = c;
            end
         end
      end
      x.ovf = m_ovf; x.unf = m_unf; x.wrap = w; x.err = m_err;
      x.eexp = m_exp; x.egot = m_got; x.busy = (m_state == 1);
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         x = sb.pop_front();
         check("ovf_cnt", 32'(bus.ovf_cnt), 32'(x.ovf));
         check("unf_cnt", 32'(bus.unf_cnt), 32'(x.unf));
         check("wrap_ev", 32'(bus.wrap_ev), 32'(x.wrap));
         check("err",     32'(bus.err),     32'(x.err));
         check("err_exp", 32'(bus.err_exp), 32'(x.eexp));
         check("err_got", 32'(bus.err_got), 32'(x.egot));
         check("busy",    32'(bus.busy),    32'(x.busy));
      end
      if (bus.wrap_ev === 1'b1) wrap_seen++;
   endtask

   initial begin
      logic [3:0] c;
      logic       s;
      bus.en = 1'b0; bus.sel = 1'b0; bus.cnt_in = '0; bus.clr = 1'b0;

      // 1: up count through one overflow
      step(1, 0, 0, 4'd0, 0);
      step(1, 0, 0, 4'd0, 0);
      check("rst_ovf", 32'(bus.ovf_cnt), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      wrap_seen = 0;
      for (int i = 0; i < 20; i++) step(0, 1, 1, 4'(i), 0);
      check("t1_err", 32'(bus.err), 32'd0);
      check("t1_ovf", 32'(bus.ovf_cnt), 32'd1);
      check("t1_unf", 32'(bus.unf_cnt), 32'd0);
      check("t1_pulses", 32'(wrap_seen), 32'd1);

      // 2: down count, first step 0 -> 15 is an underflow
      step(1, 0, 0, 4'd0, 0);
      step(0, 1, 0, 4'd0, 0);
      step(0, 1, 0, 4'd15, 0);
      check("t2_unf1", 32'(bus.unf_cnt), 32'd1);
      check("t2_wrap1", 32'(bus.wrap_ev), 32'd1);
      for (int i = 2; i < 20; i++) step(0, 1, 0, 4'(0 - i), 0);
      check("t2_err", 32'(bus.err), 32'd0);

      // 3: step fault then hold
      step(1, 0, 0, 4'd0, 0);
      for (int i = 0; i <= 5; i++) step(0, 1, 1, 4'(i), 0);
      step(0, 1, 1, 4'd9, 0);
      check("t3_err", 32'(bus.err), 32'd1);
      check("t3_exp", 32'(bus.err_exp), 32'd6);
      check("t3_got", 32'(bus.err_got), 32'd9);
      check("t3_busy", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 10; i++) step(0, 1'($urandom), 1'($urandom), 4'($urandom), 0);
      check("t3_hold_exp", 32'(bus.err_exp), 32'd6);

      // 4: random direction, correct counter
      step(1, 0, 0, 4'd0, 0);
      m_ovf_total = 0; m_unf_total = 0;
      c = 4'($urandom);
      for (int i = 0; i < 100; i++) begin
         s = 1'($urandom);
         step(0, 1, s, c, 0);
         c = s ? 4'(c + 4'd1) : 4'(c - 4'd1);
      end
      check("t4_err", 32'(bus.err), 32'd0);
      check("t4_ovf", 32'(bus.ovf_cnt), 32'(m_ovf_total));
      check("t4_unf", 32'(bus.unf_cnt), 32'(m_unf_total));

      // 5: 300 overflows saturate at 255
      step(1, 0, 0, 4'd0, 0);
      wrap_seen = 0;
      for (int i = 0; i <= 4800; i++) step(0, 1, 1, 4'(i), 0);
      check("t5_ovf_sat", 32'(bus.ovf_cnt), 32'd255);
      check("t5_pulses", 32'(wrap_seen), 32'd300);

      // 6: clr wins over a mismatch; en=0 resync is legal
      step(1, 0, 0, 4'd0, 0);
      for (int i = 0; i <= 3; i++) step(0, 1, 1, 4'(i), 0);
      step(0, 1, 1, 4'd9, 1);
      check("t6_err", 32'(bus.err), 32'd0);
      check("t6_busy", 32'(bus.busy), 32'd0);
      for (int i = 0; i <= 6; i++) step(0, 1, 1, 4'(i), 0);
      step(0, 0, 1, 4'd0, 0);
      for (int i = 0; i <= 4; i++) step(0, 1, 1, 4'(i), 0);
      check("t6_resync_err", 32'(bus.err), 32'd0);
      check("t6_resync_busy", 32'(bus.busy), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
